// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin arbiter that lets NUM_REQ requesters share a
// single i2c_master. The winner's address/data are registered and handed to
// the master with a one-cycle m_start pulse; completion (or timeout) is
// returned to the owning requester as a one-cycle done_o/err_o pulse.
//
// Handshake: a requester raises req[i] (level) with its address/data slice
// valid and holds it until it sees done_o[i] or err_o[i]. gnt[i] is high
// from ISSUE through WAIT. The master sees m_start for exactly one cycle and
// answers with m_done, which is only looked at while in WAIT.
//
// Optional feature: define I2C_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles without m_done (err_o pulse). Without the macro the
// arbiter waits forever and err_o is constant 0.
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*7-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [NUM_REQ-1:0]   err_o,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_data,
    input  logic                 m_done,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = PW + 1;
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] owner_nxt;
    logic [PW-1:0] win_idx;
    logic          win_found;
    logic [CW-1:0] cand;
    logic          timeout;
    logic [6:0]    addr_arr [NUM_REQ];
    logic [7:0]    data_arr [NUM_REQ];

    // Unpack the flat address/data buses into per-requester slices.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_arr[g] = req_addr[7*g +: 7];
        assign data_arr[g] = req_data[8*g +: 8];
    end

    // Round-robin search: start at ptr, wrap at NUM_REQ-1, first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!win_found && req[cand[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    // Pointer value after the current owner finishes: owner+1 modulo NUM_REQ.
    always_comb begin
        owner_nxt = '0;
        if (owner != PW'(NUM_REQ - 1)) begin
            owner_nxt = owner + PW'(1);
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [19:0] wait_cnt;

    // Count clock cycles spent in WAIT; cleared in every other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 20'd1;
        end
    end

    assign timeout = (state == S_WAIT) && (wait_cnt == TIMEOUT_LAST);
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign unused_timeout = ^TIMEOUT_LAST;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; m_done has priority over timeout in WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (m_done || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded directly from the state.
    always_comb begin
        m_start   = (state == S_ISSUE);
        busy      = (state != S_IDLE);
        state_dbg = state;
    end

    // Grant, captured transaction, completion pulses and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            owner  <= '0;
            gnt    <= '0;
            done_o <= '0;
            err_o  <= '0;
            m_addr <= '0;
            m_data <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        owner        <= win_idx;
                        gnt          <= '0;
                        gnt[win_idx] <= 1'b1;
                        m_addr       <= addr_arr[win_idx];
                        m_data       <= data_arr[win_idx];
                    end
                end
                S_WAIT: begin
                    if (m_done) begin
                        done_o[owner] <= 1'b1;
                        gnt           <= '0;
                        ptr           <= owner_nxt;
                    end else if (timeout) begin
                        err_o[owner] <= 1'b1;
                        gnt          <= '0;
                        ptr          <= owner_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16): directed table,
// hand-written corner sequences and a randomized run against a
// transaction-level round-robin model. Timeout checks follow I2C_ARB_TIMEOUT_EN.
module tb_i2c_master_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [27:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        m_done = 1'b0;
  logic [3:0]  gnt;
  logic [3:0]  done_o;
  logic [3:0]  err_o;
  logic        m_start;
  logic [6:0]  m_addr;
  logic [7:0]  m_data;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  int m_ptr    = 0;

  // scoreboard entries: {expected gnt, expected m_addr, expected m_data}
  logic [18:0] exp_q[$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_gnt;
    logic [6:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  i2c_master_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_addr(req_addr),
    .req_data(req_data),
    .gnt(gnt),
    .done_o(done_o),
    .err_o(err_o),
    .m_start(m_start),
    .m_addr(m_addr),
    .m_data(m_data),
    .m_done(m_done),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    req    = '0;
    m_done = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slice i: addr 0x4E+i, data 0xA3+i (slice 2 = 7'h50 / 8'hA5)
  task automatic set_fixed();
    for (int i = 0; i < N; i++) begin
      req_addr[7*i +: 7] = 7'(32'h4E + i);
      req_data[8*i +: 8] = 8'(32'hA3 + i);
    end
  endtask

  // reference model: first requester at or after p, wrapping
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic void push_exp(input int w);
    if (w < 0) exp_q.push_back('0);
    else exp_q.push_back({4'(1 << w), req_addr[7*w +: 7], req_data[8*w +: 8]});
  endfunction

  // driver: one full transaction. mode 0 = quiet, 1 = perturb inputs, 2 = owner drops req in WAIT
  task automatic do_txn(input logic [3:0] r, input int wait_len, input int mode);
    logic [18:0] e;
    logic [3:0]  eg;
    logic [6:0]  ea;
    logic [7:0]  ed;
    req = r;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
      return;
    end
    e = exp_q.pop_front();
    {eg, ea, ed} = e;
    step();
    if (eg == 4'b0) begin
      check("idle_busy", busy, 0);
      check("idle_start", m_start, 0);
      check("idle_gnt", gnt, 0);
      return;
    end
    check("issue_start", m_start, 1);
    check("issue_gnt", gnt, eg);
    check("issue_addr", m_addr, ea);
    check("issue_data", m_data, ed);
    check("issue_busy", busy, 1);
    check("issue_done_clear", done_o, 0);
    if (mode == 1) begin
      req      = 4'($urandom_range(0, 15));
      req_addr = 28'($urandom);
      req_data = $urandom;
      m_done   = 1'($urandom_range(0, 1));
    end
    step();
    m_done = 1'b0;
    check("wait_start", m_start, 0);
    check("wait_gnt", gnt, eg);
    check("wait_addr", m_addr, ea);
    check("wait_data", m_data, ed);
    check("wait_done", done_o, 0);
    if (mode == 2) req = req & ~eg;
    for (int k = 0; k < wait_len; k++) begin
      if (mode == 1) begin
        req      = 4'($urandom_range(0, 15));
        req_addr = 28'($urandom);
        req_data = $urandom;
      end
      step();
      check("hold_gnt", gnt, eg);
      check("hold_addr", m_addr, ea);
      check("hold_data", m_data, ed);
      check("hold_flags", {busy, done_o, err_o}, {1'b1, 8'h00});
    end
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("done_pulse", done_o, eg);
    check("done_gnt", gnt, 0);
    check("done_busy", busy, 0);
    check("done_err", err_o, 0);
    check("done_start", m_start, 0);
  endtask

  initial begin
    vecs[0] = '{4'b0100, 4'b0100, 7'h50, 8'hA5};
    vecs[1] = '{4'b1111, 4'b1000, 7'h51, 8'hA6};
    vecs[2] = '{4'b1111, 4'b0001, 7'h4E, 8'hA3};
    vecs[3] = '{4'b0110, 4'b0010, 7'h4F, 8'hA4};
    vecs[4] = '{4'b0011, 4'b0001, 7'h4E, 8'hA3};
    vecs[5] = '{4'b1001, 4'b1000, 7'h51, 8'hA6};
    vecs[6] = '{4'b0000, 4'b0000, 7'h00, 8'h00};
    vecs[7] = '{4'b1010, 4'b0010, 7'h4F, 8'hA4};
    vecs[8] = '{4'b1010, 4'b1000, 7'h51, 8'hA6};
    vecs[9] = '{4'b0100, 4'b0100, 7'h50, 8'hA5};

    // reset state
    #2 rst = 1'b0;
    step();
    step();
    check("reset_outputs", {gnt, done_o, err_o, m_start, busy}, 0);
    check("reset_bus", {m_addr, m_data}, 0);
    rst = 1'b1;
    step();

    // spurious m_done in IDLE
    m_done = 1'b1;
    repeat (3) begin
      step();
      check("spurious_done", {busy, m_start, done_o, gnt}, 0);
    end
    m_done = 1'b0;

    // directed table from a fresh reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_fixed();
      exp_q.push_back({vecs[i].exp_gnt, vecs[i].exp_addr, vecs[i].exp_data});
      do_txn(vecs[i].req, i % 3, i % 2);
    end

    // fairness: all requesting from reset -> 0,1,2,3,0,1,2,3
    do_reset();
    set_fixed();
    for (int t = 0; t < 8; t++) begin
      exp_q.push_back({4'(1 << (t % 4)), 7'(32'h4E + t % 4), 8'(32'hA3 + t % 4)});
      do_txn(4'hF, t % 3, 0);
    end

    // owner drops req during WAIT
    do_reset();
    set_fixed();
    exp_q.push_back({4'b0010, 7'h4F, 8'hA4});
    do_txn(4'b0010, 3, 2);
    check("drop_req_final", req, 0);

    // reset during WAIT
    do_reset();
    set_fixed();
    req = 4'b0010;
    step();
    step();
    check("pre_reset_gnt", gnt, 4'b0010);
    #2 rst = 1'b0;
    #1;
    check("async_reset_flags", {gnt, done_o, err_o, m_start, busy}, 0);
    check("async_reset_bus", {m_addr, m_data}, 0);
    req = '0;
    step();
    step();
    rst = 1'b1;
    repeat (4) begin
      step();
      check("post_reset_quiet", {m_start, busy, done_o, err_o}, 0);
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // timeout: err_o 16 cycles after entering WAIT
    do_reset();
    set_fixed();
    req = 4'b0001;
    step();
    req = '0;
    step();
    for (int k = 1; k < TO; k++) begin
      step();
      check("to_pending", {busy, err_o}, 5'b10000);
    end
    step();
    check("to_err", err_o, 4'b0001);
    check("to_flags", {done_o, gnt, busy}, 0);
    step();
    check("to_err_clear", err_o, 0);
    req = 4'b0011;
    step();
    check("to_ptr_adv", gnt, 4'b0010);
    req = '0;
    step();
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("to_next_done", done_o, 4'b0010);

    // m_done on the timeout cycle wins
    do_reset();
    req = 4'b0100;
    step();
    req = '0;
    step();
    repeat (TO - 1) step();
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("to_race_done", done_o, 4'b0100);
    check("to_race_err", err_o, 0);
`else
    // no timeout: WAIT is held indefinitely
    do_reset();
    req = 4'b0001;
    step();
    req = '0;
    step();
    repeat (40) step();
    check("no_to_busy", {busy, gnt}, 5'b10001);
    check("no_to_err", err_o, 0);
    m_done = 1'b1;
    step();
    m_done = 1'b0;
    check("no_to_done", done_o, 4'b0001);
`endif

    // randomized run against the round-robin model
    do_reset();
    m_ptr = 0;
    repeat (40) begin
      logic [3:0] r;
      int w;
      r        = 4'($urandom_range(0, 15));
      req_addr = 28'($urandom);
      req_data = $urandom;
      w        = rr_pick(r, m_ptr);
      push_exp(w);
      do_txn(r, $urandom_range(0, 4), 1);
      if (w >= 0) m_ptr = (w + 1) % N;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one i2c_master (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, clk cycles allowed in WAIT before abort (legal 1..2^20-1).
REQ-003 SHALL have port clk  input  1  system clock, one clock domain; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester transaction request, level, held until done_o/err_o.
REQ-006 SHALL have port req_addr  input  NUM_REQ*7  7-bit slave address; requester i at bits [7i+6:7i].
REQ-007 SHALL have port req_data  input  NUM_REQ*8  write byte; requester i at bits [8i+7:8i].
REQ-008 SHALL have port gnt  output  NUM_REQ  one-hot grant, high for the owning requester from ISSUE through WAIT.
REQ-009 SHALL have port done_o  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port err_o  output  NUM_REQ  one-cycle timeout pulse to the owning requester.
REQ-011 SHALL have port m_start  output  1  one-cycle start pulse to i2c_master.
REQ-012 SHALL have port m_addr  output  7  registered address to i2c_master, stable from ISSUE until the next ISSUE.
REQ-013 SHALL have port m_data  output  8  registered data byte to i2c_master, same stability as m_addr.
REQ-014 SHALL have port m_done  input  1  transaction-complete indication from i2c_master, sampled in WAIT only.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, ISSUE and WAIT, all registered.
REQ-017 In IDLE with any req bit high, SHALL select winner w by round-robin: search from index ptr upward, wrapping NUM_REQ-1 to 0, first set bit wins.
REQ-018 On the edge that samples a request in IDLE, SHALL enter ISSUE, latch m_addr/m_data from slice w, and set gnt[w].
REQ-019 ISSUE SHALL last exactly one cycle with m_start=1, then go to WAIT, so m_start rises one cycle after req is sampled.
REQ-020 In WAIT, m_done=1 SHALL return the block to IDLE, pulse done_o[w] for one cycle, clear gnt, and set ptr to (w+1) mod NUM_REQ.
REQ-021 m_done in IDLE or ISSUE SHALL be ignored.
REQ-022 Deassertion of req[w] during ISSUE or WAIT SHALL NOT abort the transaction; the transaction completes normally.
REQ-023 req changes on non-owners SHALL NOT affect gnt, m_addr or m_data until the block returns to IDLE.
REQ-024 A requester still asserting req after its done_o SHALL rank lowest in the next arbitration.
REQ-025 Back-to-back transactions SHALL be allowed with minimum one IDLE cycle between them (done_o cycle = IDLE cycle).
REQ-026 At most one bit of gnt, done_o or err_o SHALL be high in any cycle.

Reset
REQ-027 rst low SHALL immediately force state=IDLE, ptr=0, gnt=0, done_o=0, err_o=0, m_start=0, m_addr=0, m_data=0, busy=0 and clear the timeout counter.
REQ-028 Reset asserted mid-transaction SHALL abort it with no done_o/err_o, and SHALL NOT re-issue m_start after release until a fresh IDLE arbitration.

Configuration
REQ-029 Macro I2C_ARB_TIMEOUT_EN defined: SHALL count cycles in WAIT; on reaching TIMEOUT_CYCLES without m_done, SHALL pulse err_o[w], go to IDLE, clear gnt and advance ptr as in REQ-020.
REQ-030 With I2C_ARB_TIMEOUT_EN defined, m_done in the same cycle as timeout SHALL win: done_o pulses and err_o stays 0.
REQ-031 Macro I2C_ARB_TIMEOUT_EN undefined: SHALL have no counter, wait in WAIT indefinitely, tie err_o to 0 and ignore TIMEOUT_CYCLES.

Verification
REQ-032 Single request: req=4'b0100, addr2=7'h50, data2=8'hA5 -> m_start one cycle later; m_addr=7'h50, m_data=8'hA5, gnt=4'b0100; m_done -> done_o=4'b0100 for one cycle, busy=0.
REQ-033 Fairness: req=4'b1111 held for 8 transactions from reset -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Owner drops req in WAIT: gnt and m_addr/m_data hold; done_o still pulses on m_done.
REQ-035 Reset during WAIT with gnt=4'b0010 -> all outputs 0 immediately; no done_o; after release with req=0, m_start stays 0.
REQ-036 With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_done never asserted -> err_o[w] pulses 16 cycles after entering WAIT; with m_done on cycle 16 -> done_o pulses, err_o=0.
REQ-037 Spurious m_done in IDLE -> no state change, done_o=0, busy=0.
